// File: rtl/ram_arb_pkg.sv
// Shared types and constants for the RAM word arbiter.
// Word accesses are split into little-endian byte beats.
package ram_arb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        BEAT,
        CAPT,
        DONE
    } arb_state_e;

    localparam logic OWNER_M0 = 1'b0;
    localparam logic OWNER_M1 = 1'b1;

    localparam int BEATS_PER_WORD = 4;

endpackage

// File: rtl/rr_grant2.sv
// Two-input round-robin picker; on a tie the master not served last wins.
// Purely combinational, one-hot grant (bit 0 = M0, bit 1 = M1).
module rr_grant2
    import ram_arb_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last,
    output logic [1:0] grant
);

    always_comb begin
        grant = 2'b00;
        unique case (req)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = (last == OWNER_M1) ? 2'b01 : 2'b10;
            default: grant = 2'b00;
        endcase
    end

endmodule

// File: rtl/ram_word_arbiter.sv
// Shares a byte-wide RAM port between a fetch master (M0) and a
// load/store master (M1); each word access runs as four byte beats.
module ram_word_arbiter
    import ram_arb_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int RAM_WIDTH  = 8
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      m0_req,
    input  logic [ADDR_WIDTH-1:0]     m0_addr,
    output logic [DATA_WIDTH-1:0]     m0_rdata,
    output logic                      m0_ack,
    input  logic                      m1_req,
    input  logic                      m1_we,
    input  logic [ADDR_WIDTH-1:0]     m1_addr,
    input  logic [DATA_WIDTH-1:0]     m1_wdata,
    input  logic [BEATS_PER_WORD-1:0] m1_be,
    output logic [DATA_WIDTH-1:0]     m1_rdata,
    output logic                      m1_ack,
    output logic [ADDR_WIDTH-1:0]     ram_addr,
    output logic [RAM_WIDTH-1:0]      ram_wdata,
    output logic                      ram_we,
    input  logic [RAM_WIDTH-1:0]      ram_rdata,
    input  logic                      ram_busy
);

    localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ~ADDR_WIDTH'(3);

    arb_state_e                state_q, state_d;
    logic                      owner_q, owner_d;
    logic                      last_q, last_d;
    logic [ADDR_WIDTH-1:0]     base_q, base_d;
    logic                      we_q, we_d;
    logic [DATA_WIDTH-1:0]     wdata_q, wdata_d;
    logic [BEATS_PER_WORD-1:0] be_q, be_d;
    logic [1:0]                k_q, k_d;
    logic [DATA_WIDTH-1:0]     rbuf_q, rbuf_d;

    logic [ADDR_WIDTH-1:0]     ram_addr_q, ram_addr_d;
    logic [RAM_WIDTH-1:0]      ram_wdata_q, ram_wdata_d;
    logic                      ram_we_q, ram_we_d;
    logic                      m0_ack_q, m0_ack_d;
    logic                      m1_ack_q, m1_ack_d;
    logic [DATA_WIDTH-1:0]     m0_rdata_q, m0_rdata_d;
    logic [DATA_WIDTH-1:0]     m1_rdata_q, m1_rdata_d;

    logic [1:0] grant;

    rr_grant2 u_rr (
        .req   ({m1_req, m0_req}),
        .last  (last_q),
        .grant (grant)
    );

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        last_d  = last_q;
        base_d  = base_q;
        we_d    = we_q;
        wdata_d = wdata_q;
        be_d    = be_q;
        k_d     = k_q;
        rbuf_d  = rbuf_q;

        unique case (state_q)
            IDLE: begin
                if (|grant) begin
                    owner_d = grant[1] ? OWNER_M1 : OWNER_M0;
                    base_d  = (grant[1] ? m1_addr : m0_addr) & ALIGN_MASK;
                    we_d    = grant[1] & m1_we;
                    wdata_d = grant[1] ? m1_wdata : '0;
                    be_d    = grant[1] ? m1_be : '0;
                    k_d     = 2'd0;
                    state_d = BEAT;
                end
            end
            BEAT: begin
                if (!we_q) begin
                    state_d = CAPT;
                end else if (k_q == 2'd3) begin
                    state_d = DONE;
                end else begin
                    k_d = k_q + 2'd1;
                end
            end
            CAPT: begin
                if (!ram_busy) begin
                    rbuf_d[int'(k_q)*RAM_WIDTH +: RAM_WIDTH] = ram_rdata;
                    if (k_q == 2'd3) begin
                        state_d = DONE;
                    end else begin
                        k_d     = k_q + 2'd1;
                        state_d = BEAT;
                    end
                end
            end
            DONE: begin
                last_d  = owner_q;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs are registered from next-state values so they line up with state_q.
    always_comb begin
        ram_addr_d  = ram_addr_q;
        ram_wdata_d = ram_wdata_q;
        ram_we_d    = 1'b0;
        m0_rdata_d  = m0_rdata_q;
        m1_rdata_d  = m1_rdata_q;

        if (state_d == BEAT) begin
            ram_addr_d  = base_d + ADDR_WIDTH'(k_d);
            ram_wdata_d = wdata_d[int'(k_d)*RAM_WIDTH +: RAM_WIDTH];
            ram_we_d    = we_d & be_d[k_d];
        end

        m0_ack_d = (state_d == DONE) && (owner_d == OWNER_M0);
        m1_ack_d = (state_d == DONE) && (owner_d == OWNER_M1);

        if ((state_d == DONE) && !we_d) begin
            if (owner_d == OWNER_M0) m0_rdata_d = rbuf_d;
            else                     m1_rdata_d = rbuf_d;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            owner_q     <= OWNER_M0;
            last_q      <= OWNER_M1;
            base_q      <= '0;
            we_q        <= 1'b0;
            wdata_q     <= '0;
            be_q        <= '0;
            k_q         <= 2'd0;
            rbuf_q      <= '0;
            ram_addr_q  <= '0;
            ram_wdata_q <= '0;
            ram_we_q    <= 1'b0;
            m0_ack_q    <= 1'b0;
            m1_ack_q    <= 1'b0;
            m0_rdata_q  <= '0;
            m1_rdata_q  <= '0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            last_q      <= last_d;
            base_q      <= base_d;
            we_q        <= we_d;
            wdata_q     <= wdata_d;
            be_q        <= be_d;
            k_q         <= k_d;
            rbuf_q      <= rbuf_d;
            ram_addr_q  <= ram_addr_d;
            ram_wdata_q <= ram_wdata_d;
            ram_we_q    <= ram_we_d;
            m0_ack_q    <= m0_ack_d;
            m1_ack_q    <= m1_ack_d;
            m0_rdata_q  <= m0_rdata_d;
            m1_rdata_q  <= m1_rdata_d;
        end
    end

    assign ram_addr  = ram_addr_q;
    assign ram_wdata = ram_wdata_q;
    assign ram_we    = ram_we_q;
    assign m0_ack    = m0_ack_q;
    assign m1_ack    = m1_ack_q;
    assign m0_rdata  = m0_rdata_q;
    assign m1_rdata  = m1_rdata_q;

endmodule

// File: tb/tb_ram_word_arbiter.sv
// Bench for ram_word_arbiter: byte RAM model, ack scoreboard and
// per-scenario tasks for latency, steering, busy, wrap and reset.
module tb_ram_word_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        m0_req;
    logic [31:0] m0_addr;
    logic [31:0] m0_rdata;
    logic        m0_ack;
    logic        m1_req;
    logic        m1_we;
    logic [31:0] m1_addr;
    logic [31:0] m1_wdata;
    logic [3:0]  m1_be;
    logic [31:0] m1_rdata;
    logic        m1_ack;
    logic [31:0] ram_addr;
    logic [7:0]  ram_wdata;
    logic        ram_we;
    logic [7:0]  ram_rdata;
    logic        ram_busy;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    ram_word_arbiter dut (
        .clk       (clk),
        .reset     (reset),
        .m0_req    (m0_req),
        .m0_addr   (m0_addr),
        .m0_rdata  (m0_rdata),
        .m0_ack    (m0_ack),
        .m1_req    (m1_req),
        .m1_we     (m1_we),
        .m1_addr   (m1_addr),
        .m1_wdata  (m1_wdata),
        .m1_be     (m1_be),
        .m1_rdata  (m1_rdata),
        .m1_ack    (m1_ack),
        .ram_addr  (ram_addr),
        .ram_wdata (ram_wdata),
        .ram_we    (ram_we),
        .ram_rdata (ram_rdata),
        .ram_busy  (ram_busy)
    );

    // Byte RAM: 1 KiB window, garbage on the data bus while busy.
    logic [7:0]  mem [0:1023];
    logic        pl_en = 1'b0;
    logic [9:0]  pl_addr = '0;
    logic [31:0] pl_word = '0;

    typedef struct packed {
        logic [31:0] addr;
        logic [7:0]  data;
    } wr_t;
    wr_t wlog[$];

    assign ram_rdata = ram_busy ? 8'hEE : mem[ram_addr[9:0]];

    always @(posedge clk) begin
        if (pl_en) begin
            for (int i = 0; i < 4; i++)
                mem[pl_addr + 10'(i)] <= pl_word[8*i +: 8];
        end
        if (ram_we) begin
            mem[ram_addr[9:0]] <= ram_wdata;
            wlog.push_back({ram_addr, ram_wdata});
        end
    end

    typedef struct packed {
        logic        m;
        logic [31:0] data;
    } exp_t;
    exp_t sb[$];

    logic [31:0] exp_m0 = '0;
    logic [31:0] exp_m1 = '0;

    always @(negedge clk) begin
        if (!reset && (m0_ack || m1_ack)) begin
            exp_t e;
            logic [31:0] obs;
            checks++;
            if (m0_ack && m1_ack) begin
                errors++;
                $display("FAIL sb_both_ack: m0_ack=1 m1_ack=1, expected one");
            end else if (sb.size() == 0) begin
                errors++;
                $display("FAIL sb_unexpected: ack m0=%0b m1=%0b, none expected",
                         m0_ack, m1_ack);
            end else begin
                e = sb.pop_front();
                obs = m1_ack ? m1_rdata : m0_rdata;
                if (m1_ack !== e.m || obs !== e.data) begin
                    errors++;
                    $display("FAIL sb_ack: got M%0d data %08h, expected M%0d data %08h",
                             m1_ack, obs, e.m, e.data);
                end
            end
        end
    end

    task automatic preload(input logic [9:0] a, input logic [31:0] w);
        @(negedge clk);
        pl_en = 1'b1;
        pl_addr = a;
        pl_word = w;
        @(negedge clk);
        pl_en = 1'b0;
    endtask

    task automatic wait_ack(input logic m, output int lat);
        lat = -1;
        for (int n = 1; n <= 60; n++) begin
            @(negedge clk);
            if (m ? m1_ack : m0_ack) begin
                lat = n;
                break;
            end
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        m0_req = 1'b0;
        m1_req = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        exp_m0 = '0;
        exp_m1 = '0;
        sb.delete();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        m0_req = 1'b0;
        m1_req = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({m0_rdata, m1_rdata, m0_ack, m1_ack} !== '0) begin
            errors++;
            $display("FAIL reset_master: m0_rdata=%08h m1_rdata=%08h acks=%b%b, expected 0",
                     m0_rdata, m1_rdata, m0_ack, m1_ack);
        end
        checks++;
        if ({ram_addr, ram_wdata, ram_we} !== '0) begin
            errors++;
            $display("FAIL reset_ram: addr=%08h wdata=%02h we=%b, expected 0",
                     ram_addr, ram_wdata, ram_we);
        end
        reset = 1'b0;
    endtask

    task automatic test_m0_read();
        int lat;
        preload(10'h100, 32'h44332211);
        @(negedge clk);
        m0_addr = 32'h0000_0102;
        m0_req = 1'b1;
        exp_m0 = 32'h44332211;
        sb.push_back({1'b0, exp_m0});
        wait_ack(1'b0, lat);
        m0_req = 1'b0;
        checks++;
        if (lat !== 9) begin
            errors++;
            $display("FAIL m0_read_latency: ack at cycle %0d, expected 9", lat);
        end
        @(negedge clk);
        checks++;
        if (m0_ack !== 1'b0 || m0_rdata !== exp_m0) begin
            errors++;
            $display("FAIL m0_read_hold: ack=%b rdata=%08h, expected 0 / %08h",
                     m0_ack, m0_rdata, exp_m0);
        end
    endtask

    task automatic test_m1_write();
        int lat;
        lat = -1;
        @(negedge clk);
        wlog.delete();
        m1_addr = 32'h0000_0203;
        m1_wdata = 32'hA1B2C3D4;
        m1_be = 4'b0101;
        m1_we = 1'b1;
        m1_req = 1'b1;
        sb.push_back({1'b1, exp_m1});
        for (int n = 1; n <= 60; n++) begin
            @(negedge clk);
            if (n == 2) begin
                m1_req = 1'b0;
                m1_addr = 32'h0;
                m1_wdata = 32'hFFFF_FFFF;
                m1_be = 4'hF;
            end
            if (m1_ack) begin
                lat = n;
                break;
            end
        end
        checks++;
        if (lat !== 5) begin
            errors++;
            $display("FAIL m1_write_latency: ack at cycle %0d, expected 5", lat);
        end
        checks++;
        if (wlog.size() !== 2) begin
            errors++;
            $display("FAIL m1_write_count: %0d byte writes, expected 2", wlog.size());
        end else begin
            checks++;
            if (wlog[0] !== {32'h200, 8'hD4} || wlog[1] !== {32'h202, 8'hB2}) begin
                errors++;
                $display("FAIL m1_write_bytes: %08h=%02h %08h=%02h, expected 200=D4 202=B2",
                         wlog[0].addr, wlog[0].data, wlog[1].addr, wlog[1].data);
            end
        end
        checks++;
        if (m0_rdata !== exp_m0) begin
            errors++;
            $display("FAIL m0_untouched_by_write: m0_rdata=%08h, expected %08h",
                     m0_rdata, exp_m0);
        end
        m1_we = 1'b0;
    endtask

    task automatic test_busy();
        int lat;
        lat = -1;
        @(negedge clk);
        m0_addr = 32'h0000_0100;
        m0_req = 1'b1;
        sb.push_back({1'b0, exp_m0});
        for (int n = 1; n <= 60; n++) begin
            @(negedge clk);
            ram_busy = (n >= 4 && n <= 6);
            if (m0_ack) begin
                lat = n;
                break;
            end
        end
        ram_busy = 1'b0;
        m0_req = 1'b0;
        checks++;
        if (lat !== 12) begin
            errors++;
            $display("FAIL busy_latency: ack at cycle %0d, expected 12", lat);
        end
    endtask

    task automatic test_wrap();
        int lat;
        logic [31:0] a;
        preload(10'h3FC, 32'hDDCCBBAA);
        @(negedge clk);
        m1_addr = 32'hFFFF_FFFC;
        m1_we = 1'b0;
        m1_req = 1'b1;
        exp_m1 = 32'hDDCCBBAA;
        sb.push_back({1'b1, exp_m1});
        lat = -1;
        for (int n = 1; n <= 60; n++) begin
            @(negedge clk);
            if (n == 1 || n == 3 || n == 5 || n == 7) begin
                a = 32'hFFFF_FFFC + 32'(n / 2);
                checks++;
                if (ram_addr !== a || ram_we !== 1'b0) begin
                    errors++;
                    $display("FAIL wrap_addr: cycle %0d addr=%08h we=%b, expected %08h / 0",
                             n, ram_addr, ram_we, a);
                end
            end
            if (m1_ack) begin
                lat = n;
                break;
            end
        end
        m1_req = 1'b0;
        checks++;
        if (lat !== 9) begin
            errors++;
            $display("FAIL wrap_latency: ack at cycle %0d, expected 9", lat);
        end
        @(negedge clk);
        m1_addr = 32'hFFFF_FFFF;
        m1_req = 1'b1;
        sb.push_back({1'b1, exp_m1});
        @(negedge clk);
        checks++;
        if (ram_addr !== 32'hFFFF_FFFC) begin
            errors++;
            $display("FAIL unaligned_base: addr=%08h, expected FFFFFFFC", ram_addr);
        end
        wait_ack(1'b1, lat);
        m1_req = 1'b0;
        checks++;
        if (lat !== 8 || m0_rdata !== exp_m0) begin
            errors++;
            $display("FAIL unaligned_read: lat=%0d m0_rdata=%08h, expected 8 / %08h",
                     lat, m0_rdata, exp_m0);
        end
    endtask

    task automatic test_alternate();
        int acks;
        int ack_cyc[4];
        int exp_cyc[4];
        exp_cyc = '{9, 19, 29, 39};
        preload(10'h300, 32'hCAFEF00D);
        preload(10'h340, 32'h0BADBEEF);
        do_reset();
        @(negedge clk);
        m0_addr = 32'h300;
        m1_addr = 32'h340;
        m1_we = 1'b0;
        m0_req = 1'b1;
        m1_req = 1'b1;
        for (int i = 0; i < 2; i++) begin
            sb.push_back({1'b0, 32'hCAFEF00D});
            sb.push_back({1'b1, 32'h0BADBEEF});
        end
        acks = 0;
        for (int n = 1; n <= 60 && acks < 4; n++) begin
            @(negedge clk);
            if (m0_ack || m1_ack) begin
                ack_cyc[acks] = n;
                acks++;
            end
        end
        m0_req = 1'b0;
        m1_req = 1'b0;
        exp_m0 = 32'hCAFEF00D;
        exp_m1 = 32'h0BADBEEF;
        checks++;
        if (acks !== 4) begin
            errors++;
            $display("FAIL alt_count: %0d acks, expected 4", acks);
        end else begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (ack_cyc[i] !== exp_cyc[i]) begin
                    errors++;
                    $display("FAIL alt_timing: ack %0d at cycle %0d, expected %0d",
                             i, ack_cyc[i], exp_cyc[i]);
                end
            end
        end
        repeat (3) @(negedge clk);
        checks++;
        if (sb.size() !== 0) begin
            errors++;
            $display("FAIL alt_pending: %0d expected acks missing", sb.size());
        end
    endtask

    task automatic test_reset_mid_write();
        int late;
        preload(10'h000, 32'h0);
        @(negedge clk);
        wlog.delete();
        m1_addr = 32'h0000_0000;
        m1_wdata = 32'h11223344;
        m1_be = 4'hF;
        m1_we = 1'b1;
        m1_req = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        m1_req = 1'b0;
        @(negedge clk);
        checks++;
        if ({m0_rdata, m1_rdata, m0_ack, m1_ack, ram_addr, ram_wdata, ram_we} !== '0) begin
            errors++;
            $display("FAIL reset_mid_outputs: rd=%08h/%08h ack=%b%b addr=%08h wd=%02h we=%b",
                     m0_rdata, m1_rdata, m0_ack, m1_ack, ram_addr, ram_wdata, ram_we);
        end
        reset = 1'b0;
        exp_m0 = '0;
        exp_m1 = '0;
        late = 0;
        repeat (12) begin
            @(negedge clk);
            if (m1_ack) late++;
        end
        checks++;
        if (late !== 0) begin
            errors++;
            $display("FAIL reset_mid_ack: %0d acks after abort, expected 0", late);
        end
        checks++;
        if (wlog.size() !== 2 || wlog[0] !== {32'h0, 8'h44} || wlog[1] !== {32'h1, 8'h33}) begin
            errors++;
            $display("FAIL reset_mid_bytes: %0d writes, expected 2 (0=44, 1=33)", wlog.size());
        end
        m1_we = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        ram_busy = 1'b0;
        m0_req = 1'b0;
        m0_addr = '0;
        m1_req = 1'b0;
        m1_we = 1'b0;
        m1_addr = '0;
        m1_wdata = '0;
        m1_be = '0;
        test_reset();
        test_m0_read();
        test_m1_write();
        test_busy();
        test_wrap();
        test_alternate();
        test_reset_mid_write();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
